// File: rtl/piece_bag_rng.sv
// Bag-randomised Tetris piece generator: a Galois LFSR deals every piece type once per bag
// into a preview queue that the game pops with a pop/valid handshake.
module piece_bag_rng #(
  parameter int unsigned       LFSR_W        = 16,
  parameter logic [LFSR_W-1:0] TAPS          = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED          = 16'hACE1,
  parameter int unsigned       NUM_TYPES     = 7,
  parameter int unsigned       PREVIEW_DEPTH = 3,
  parameter int unsigned       MAX_TRIES     = 16,
  localparam int unsigned      IDX_W         = $clog2(NUM_TYPES),
  localparam int unsigned      QD            = PREVIEW_DEPTH + 1,
  localparam int unsigned      CNT_W         = $clog2(QD + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             seed_load,
  input  logic [LFSR_W-1:0]                seed_in,
  input  logic                             pop,
  output logic [IDX_W-1:0]                 piece,
  output logic                             piece_valid,
  output logic [PREVIEW_DEPTH*IDX_W-1:0]   preview,
  output logic [CNT_W-1:0]                 queue_count,
  output logic [IDX_W:0]                   bag_remaining
);

  localparam int unsigned MW    = 1 << IDX_W;
  localparam int unsigned RW    = IDX_W + 1;
  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [MW-1:0] FULL_MASK = MW'((64'd1 << NUM_TYPES) - 64'd1);

  typedef enum logic {FILL, READY} state_t;

  state_t               state, state_n;
  logic [LFSR_W-1:0]    lfsr, lfsr_n;
  logic [IDX_W-1:0]     q   [QD];
  logic [IDX_W-1:0]     q_n [QD];
  logic [CNT_W-1:0]     count_n, wr_pos;
  logic [MW-1:0]        bag_mask, mask_n;
  logic [TRY_W-1:0]     try_cnt, try_n;
  logic [IDX_W-1:0]     cand, low_free, acc_idx;
  logic [RW-1:0]        ones, rem_n;
  logic                 do_pop, draw_en, hit, force_acc, push;

  // State register; seed_load restarts filling
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    if (seed_load) begin
      state_n = FILL;
    end else begin
      case (state)
        FILL:    if (push && !do_pop && queue_count == CNT_W'(QD - 1)) state_n = READY;
        READY:   if (do_pop) state_n = FILL;
        default: state_n = FILL;
      endcase
    end
  end

  // FSM outputs: one draw attempt per FILL cycle while there is room
  always_comb begin
    draw_en = 1'b0;
    if (state == FILL) draw_en = (queue_count < CNT_W'(QD)) || do_pop;
  end

  // Draw decision; the padded mask keeps the candidate index in range
  always_comb begin
    do_pop    = pop && piece_valid;
    lfsr_n    = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
    cand      = lfsr[IDX_W-1:0];
    hit       = (32'(cand) < NUM_TYPES) && !bag_mask[cand];
    force_acc = !hit && (try_cnt == TRY_W'(MAX_TRIES - 1));
    low_free  = '0;
    for (int i = int'(NUM_TYPES) - 1; i >= 0; i--) begin
      if (!bag_mask[i]) low_free = IDX_W'(i);
    end
    acc_idx = hit ? cand : low_free;
    push    = draw_en && (hit || force_acc);
    try_n   = try_cnt;
    if (draw_en) try_n = push ? '0 : try_cnt + TRY_W'(1);
  end

  // Queue shift/write and bag bookkeeping
  always_comb begin
    for (int i = 0; i < QD; i++) q_n[i] = q[i];
    wr_pos = queue_count;
    if (do_pop) begin
      for (int i = 0; i < QD - 1; i++) q_n[i] = q[i+1];
      q_n[QD-1] = '0;
      wr_pos    = queue_count - CNT_W'(1);
    end
    if (push) begin
      for (int i = 0; i < QD; i++) begin
        if (CNT_W'(i) == wr_pos) q_n[i] = acc_idx;
      end
    end
    count_n = queue_count + CNT_W'(push) - CNT_W'(do_pop);
    mask_n  = bag_mask;
    if (push) begin
      mask_n = bag_mask | (MW'(1) << acc_idx);
      if (mask_n == FULL_MASK) mask_n = '0;
    end
    ones = '0;
    for (int i = 0; i < NUM_TYPES; i++) ones = ones + RW'(mask_n[i]);
    rem_n = RW'(NUM_TYPES) - ones;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr          <= SEED;
      for (int i = 0; i < QD; i++) q[i] <= '0;
      queue_count   <= '0;
      bag_mask      <= '0;
      try_cnt       <= '0;
      piece_valid   <= 1'b0;
      bag_remaining <= RW'(NUM_TYPES);
    end else if (seed_load) begin
      lfsr          <= (seed_in == '0) ? SEED : seed_in;
      for (int i = 0; i < QD; i++) q[i] <= '0;
      queue_count   <= '0;
      bag_mask      <= '0;
      try_cnt       <= '0;
      piece_valid   <= 1'b0;
      bag_remaining <= RW'(NUM_TYPES);
    end else begin
      lfsr          <= lfsr_n;
      for (int i = 0; i < QD; i++) q[i] <= q_n[i];
      queue_count   <= count_n;
      bag_mask      <= mask_n;
      try_cnt       <= try_n;
      piece_valid   <= (count_n != '0);
      bag_remaining <= rem_n;
    end
  end

  // Head and preview come straight from the queue flops; vacated slots hold 0
  assign piece = q[0];
  always_comb begin
    for (int i = 0; i < PREVIEW_DEPTH; i++) preview[i*IDX_W +: IDX_W] = q[i+1];
  end

endmodule

// File: tb/tb_piece_bag_rng.sv
// Self-checking bench for piece_bag_rng: default instance plus a forced-accept instance.
module tb_piece_bag_rng;

  logic        clk = 1'b0;
  logic        rst, seed_load, pop;
  logic [15:0] seed_in;
  logic [2:0]  piece;
  logic        piece_valid;
  logic [8:0]  preview;
  logic [2:0]  queue_count;
  logic [3:0]  bag_remaining;

  logic        rst2, pop2;
  logic        seed_load2 = 1'b0;
  logic [15:0] seed_in2 = 16'h0;
  logic [2:0]  piece2;
  logic        pv2;
  logic [8:0]  preview2;
  logic [2:0]  qc2;
  logic [3:0]  br2;

  int n_tests = 0;
  int n_fail  = 0;
  int sb[$];
  int mexp[4];

  piece_bag_rng u_dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in), .pop(pop),
    .piece(piece), .piece_valid(piece_valid), .preview(preview),
    .queue_count(queue_count), .bag_remaining(bag_remaining)
  );

  piece_bag_rng #(.NUM_TYPES(5), .MAX_TRIES(1)) u_force (
    .clk(clk), .rst(rst2), .seed_load(seed_load2), .seed_in(seed_in2), .pop(pop2),
    .piece(piece2), .piece_valid(pv2), .preview(preview2),
    .queue_count(qc2), .bag_remaining(br2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int sb_next();
    if (sb.size() == 0) return -1;
    return sb.pop_front();
  endfunction

  // First four deals from a seed with no pops (7 types, 16 tries)
  task automatic model_fill(input logic [15:0] s);
    logic [15:0] l;
    logic [6:0]  m;
    int tries, n, c;
    bit acc;
    l = s; m = '0; tries = 0; n = 0;
    while (n < 4) begin
      c   = int'(l[2:0]);
      acc = 1'b0;
      if (c < 7 && !m[c]) acc = 1'b1;
      else if (tries == 15) begin
        for (int i = 6; i >= 0; i--) if (!m[i]) c = i;
        acc = 1'b1;
      end else tries++;
      if (acc) begin
        mexp[n] = c; m[c] = 1'b1; tries = 0; n++;
      end
      l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0);
    end
  endtask

  task automatic wait_full(input string tag, input int bound);
    int k = 0;
    while (queue_count != 3'd4 && k < bound) begin
      @(negedge clk); k++;
    end
    check({tag, "_full"}, int'(queue_count), 4);
  endtask

  task automatic cmp_queue(input string tag);
    check({tag, "_p0"}, int'(piece), mexp[0]);
    check({tag, "_pv1"}, int'(preview[2:0]), mexp[1]);
    check({tag, "_pv2"}, int'(preview[5:3]), mexp[2]);
    check({tag, "_pv3"}, int'(preview[8:6]), mexp[3]);
  endtask

  task automatic run_seq(input logic [15:0] s, input int n, input bit cmp, input string tag);
    int got = 0;
    int cyc = 0;
    @(negedge clk); seed_load = 1'b1; seed_in = s; pop = 1'b0;
    @(negedge clk); seed_load = 1'b0;
    while (got < n && cyc < 5000) begin
      if (piece_valid && (cyc % 3 != 1)) begin
        pop = 1'b1;
        if (cmp) check(tag, int'(piece), sb_next());
        else     sb.push_back(int'(piece));
        got++;
      end else pop = 1'b0;
      @(negedge clk); cyc++;
    end
    pop = 1'b0;
    check({tag, "_n"}, got, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, npop, cyc, gmask, prev_br, cur_br;
    bit ok, wrapped;
    rst = 1'b1; seed_load = 1'b0; pop = 1'b0; seed_in = '0;
    rst2 = 1'b1; pop2 = 1'b0;

    // Reset values and initial fill
    repeat (3) @(negedge clk);
    check("rst_piece", int'(piece), 0);
    check("rst_valid", int'(piece_valid), 0);
    check("rst_preview", int'(preview), 0);
    check("rst_count", int'(queue_count), 0);
    check("rst_bagrem", int'(bag_remaining), 7);
    rst = 1'b0;
    k = 0;
    while (!piece_valid && k < 17) begin @(negedge clk); k++; end
    check("first_valid", int'(piece_valid), 1);
    wait_full("rst", 65);
    model_fill(16'hACE1);
    cmp_queue("rst");
    check("fill_bagrem", int'(bag_remaining), 3);
    repeat (10) @(negedge clk);
    check("hold_count", int'(queue_count), 4);
    cmp_queue("hold");

    // Bag property over 700 pops
    npop = 0; cyc = 0; gmask = 0; ok = 1'b1; wrapped = 1'b0;
    prev_br = int'(bag_remaining);
    while (npop < 700 && cyc < 20000) begin
      if (piece_valid) begin
        pop = 1'b1;
        gmask = gmask | (1 << piece);
        npop++;
        if (npop % 7 == 0) begin
          check("bag_perm", gmask, 127);
          gmask = 0;
        end
      end else pop = 1'b0;
      @(negedge clk); cyc++;
      cur_br = int'(bag_remaining);
      if (prev_br == 1 && cur_br == 7) wrapped = 1'b1;
      else if (!(cur_br == prev_br || (cur_br == prev_br - 1 && cur_br >= 1))) ok = 1'b0;
      prev_br = cur_br;
    end
    pop = 1'b0;
    check("bag_pops", npop, 700);
    check("bagrem_steps", int'(ok), 1);
    check("bagrem_wrap", int'(wrapped), 1);

    // Pop ignored during and after seed_load while nothing is valid
    @(negedge clk); seed_load = 1'b1; seed_in = 16'h1234; pop = 1'b1;
    @(negedge clk); seed_load = 1'b0;
    check("sl_valid", int'(piece_valid), 0);
    check("sl_count", int'(queue_count), 0);
    check("sl_bagrem", int'(bag_remaining), 7);
    k = 0; ok = 1'b1;
    while (!piece_valid && k < 17) begin
      @(negedge clk); k++;
      if (!piece_valid && queue_count != 3'd0) ok = 1'b0;
    end
    pop = 1'b0;
    check("ign_count", int'(ok), 1);
    wait_full("ign", 65);
    model_fill(16'h1234);
    cmp_queue("ign");

    // Pop on a full queue
    sb.delete();
    sb.push_back(mexp[1]);
    pop = 1'b1;
    @(negedge clk); pop = 1'b0;
    check("fullpop_piece", int'(piece), sb_next());
    check("fullpop_pv1", int'(preview[2:0]), mexp[2]);
    check("fullpop_pv2", int'(preview[5:3]), mexp[3]);
    check("fullpop_count", int'(queue_count == 3'd3 || queue_count == 3'd4), 1);
    if (queue_count == 3'd3) check("fullpop_pv3", int'(preview[8:6]), 0);

    // Determinism with seed replay, and zero seed substitution
    sb.delete();
    run_seq(16'h1234, 50, 1'b0, "rec");
    check("rec_first", sb.size() >= 4 ? sb[0] : -1, mexp[0]);
    check("rec_fourth", sb.size() >= 4 ? sb[3] : -1, mexp[3]);
    run_seq(16'h1234, 50, 1'b1, "replay");
    sb.delete();
    run_seq(16'hACE1, 30, 1'b0, "recseed");
    run_seq(16'h0000, 30, 1'b1, "seed0");

    // Short async reset mid-fill
    @(negedge clk); seed_load = 1'b1; seed_in = 16'h1234;
    @(negedge clk); seed_load = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_valid", int'(piece_valid), 0);
    check("arst_count", int'(queue_count), 0);
    check("arst_piece", int'(piece), 0);
    check("arst_preview", int'(preview), 0);
    check("arst_bagrem", int'(bag_remaining), 7);
    #1 rst = 1'b0;
    wait_full("arst", 65);
    model_fill(16'hACE1);
    cmp_queue("arst");

    // Forced-accept instance: a push every FILL cycle, bags of 5
    @(negedge clk); rst2 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("force_count", int'(qc2), i);
    end
    check("force_bagrem", int'(br2), 1);
    npop = 0; cyc = 0; gmask = 0; ok = 1'b1;
    while (npop < 100 && cyc < 2000) begin
      if (pv2) begin
        pop2 = 1'b1;
        gmask = gmask | (1 << piece2);
        npop++;
        if (npop % 5 == 0) begin
          check("force_perm", gmask, 31);
          gmask = 0;
        end
      end else pop2 = 1'b0;
      @(negedge clk); cyc++;
      if (qc2 < 3'd3) ok = 1'b0;
    end
    pop2 = 1'b0;
    check("force_pops", npop, 100);
    check("force_refill", int'(ok), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
